// File: rtl/fir_out_decimator.sv
`timescale 1ns/1ps
// fir_out_decimator
//   Output stage placed after the FIR filter. It keeps every DECIM-th valid
//   sample, rounds it (half-up) by SHIFT bits, and saturates it to OUT_WIDTH.
//   The result is buffered in a first-word-fall-through FIFO that the consumer
//   reads through a valid/ready handshake. Sticky flags report clipping and
//   samples dropped on a full FIFO.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   i_valid    i_sig carries a new filter output this cycle
//   i_sig      signed FIR output sample, IN_WIDTH bits
//   o_ready    consumer accepts o_sig this cycle
//   o_valid    FIFO non-empty, so o_sig is valid
//   o_sig      signed requantised sample at the FIFO head (0 when empty)
//   o_count    current FIFO occupancy
//   clr_flags  synchronous clear of the sticky flags (a same-cycle set wins)
//   sat_flag   sticky: a kept sample was clipped
//   ovf_flag   sticky: a kept sample was dropped because the FIFO was full
module fir_out_decimator #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_valid,
    input  logic signed [IN_WIDTH-1:0]            i_sig,
    input  logic                                  o_ready,
    output logic                                  o_valid,
    output logic signed [OUT_WIDTH-1:0]           o_sig,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       o_count,
    input  logic                                  clr_flags,
    output logic                                  sat_flag,
    output logic                                  ovf_flag
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH+1);
    localparam int RW   = IN_WIDTH + 1;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    // Half-LSB offset added before the arithmetic shift; zero when no shift.
    localparam logic signed [RW-1:0] RND =
        (SHIFT > 0) ? (RW'(1) << RND_POS) : '0;
    localparam logic signed [RW-1:0] SAT_MAX =
        {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN =
        {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [PH_W-1:0]              phase;
    logic                         keep;
    logic signed [RW-1:0]         sum;
    logic signed [RW-1:0]         rnd_val;
    logic                         s1_valid;
    logic signed [RW-1:0]         s1_r;
    logic signed [OUT_WIDTH-1:0]  sat_val;
    logic                         clip;
    logic signed [OUT_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [CW-1:0]                count;
    logic                         full;
    logic                         pop;
    logic                         push_ok;
    logic                         drop;

    // Decimation phase: only advances on valid input, so gaps just pause it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (i_valid) begin
            phase <= (phase == PH_W'(DECIM-1)) ? '0 : phase + PH_W'(1);
        end
    end

    assign keep = i_valid && (phase == '0);

    // One extra bit of headroom so adding the rounding offset cannot wrap.
    assign sum     = $signed({i_sig[IN_WIDTH-1], i_sig}) + RND;
    assign rnd_val = sum >>> SHIFT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_r <= rnd_val;
            end
        end
    end

    always_comb begin
        clip    = 1'b0;
        sat_val = s1_r[OUT_WIDTH-1:0];
        if (s1_r > SAT_MAX) begin
            clip    = 1'b1;
            sat_val = SAT_MAX[OUT_WIDTH-1:0];
        end else if (s1_r < SAT_MIN) begin
            clip    = 1'b1;
            sat_val = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same
    // cycle; the write lands in the slot being vacated.
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = (count != '0) && o_ready;
    assign push_ok = s1_valid && (!full || pop);
    assign drop    = s1_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= sat_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            sat_flag <= (sat_flag && !clr_flags) || (s1_valid && clip);
            ovf_flag <= (ovf_flag && !clr_flags) || drop;
        end
    end

    assign o_valid = (count != '0);
    assign o_sig   = o_valid ? mem[rd_ptr] : '0;
    assign o_count = count;

endmodule
